// File: rtl/sprite_rom_reader_if.sv
// rtl/sprite_rom_reader_if.sv - draw request, colour ROM and plot port bundle for sprite_rom_reader
// Purpose: groups the draw-controller handshake, the colour ROM read port and
//          the VGA plot port into one bundle.
// Modports:
//   slave  - the reader engine: takes start/x0/y0/rom_q, drives busy/done,
//            rom_address and the plot/x/y/colour pixel stream.
//   master - the surrounding system: draw controller, ROM and VGA adapter.
interface sprite_rom_reader_if #(
   parameter int ADDR_W = 12,
   parameter int X_W    = 8,
   parameter int Y_W    = 7
);
   logic              start;
   logic [X_W-1:0]    x0;
   logic [Y_W-1:0]    y0;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] rom_address;
   logic [23:0]       rom_q;
   logic              plot;
   logic [X_W-1:0]    x;
   logic [Y_W-1:0]    y;
   logic [23:0]       colour;

   modport slave (
      input  start, x0, y0, rom_q,
      output busy, done, rom_address, plot, x, y, colour
   );

   modport master (
      output start, x0, y0, rom_q,
      input  busy, done, rom_address, plot, x, y, colour
   );
endinterface

// File: rtl/sprite_rom_reader.sv
// rtl/sprite_rom_reader.sv - walks a sprite through the colour ROM and emits one plot per pixel
// Purpose: on an accepted start, issues ROM addresses for a SPR_W x SPR_H sprite in
//          row-major order, carries {valid,col,row} alongside the ROM latency and
//          emits plot/x/y/colour for every non-transparent pixel.
// Ports:
//   clock  - system clock, rising edge
//   resetn - asynchronous active-low reset
//   bus    - slave side of sprite_rom_reader_if (start/x0/y0 in, busy/done out,
//            rom_address out, rom_q in, plot/x/y/colour out)
module sprite_rom_reader #(
   parameter int          ADDR_W  = 12,
   parameter int          SPR_W   = 64,
   parameter int          SPR_H   = 64,
   parameter int          X_W     = 8,
   parameter int          Y_W     = 7,
   parameter int          ROM_LAT = 2,
   parameter logic [23:0] TRANSP  = 24'hFF00FF
) (
   input logic               clock,
   input logic               resetn,
   sprite_rom_reader_if.slave bus
);
   localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
   // The {valid,col,row} pipe is ROM_LAT-1 deep; the final stage is the
   // x/y output register, so the whole path is ROM_LAT clocks (ROM_LAT >= 2).
   localparam int PD = ROM_LAT - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CW-1:0]     r_col;
   logic [RW-1:0]     r_row;
   logic [ADDR_W-1:0] r_addr;
   logic [X_W-1:0]    r_x0;
   logic [Y_W-1:0]    r_y0;
   logic [PD-1:0]     r_pv;
   logic [CW-1:0]     r_pc [PD];
   logic [RW-1:0]     r_pr [PD];
   logic              r_out_v;
   logic [X_W-1:0]    r_x;
   logic [Y_W-1:0]    r_y;
   logic [23:0]       r_colour;
   logic              w_accept;
   logic              w_last_addr;

   assign w_accept    = (r_state == S_IDLE) && bus.start;
   assign w_last_addr = (r_col == CW'(SPR_W - 1)) && (r_row == RW'(SPR_H - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = S_RUN;
         S_RUN:   if (w_last_addr) w_next = S_DRAIN;
         // Last pixel is in the output stage and nothing is behind it.
         S_DRAIN: if (r_out_v && !(|r_pv)) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Address walk: counters freeze on the last address so rom_address holds.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_col  <= '0;
         r_row  <= '0;
         r_addr <= '0;
         r_x0   <= '0;
         r_y0   <= '0;
      end else if (w_accept) begin
         r_col  <= '0;
         r_row  <= '0;
         r_addr <= '0;
         r_x0   <= bus.x0;
         r_y0   <= bus.y0;
      end else if ((r_state == S_RUN) && !w_last_addr) begin
         r_addr <= r_addr + ADDR_W'(1);
         if (r_col == CW'(SPR_W - 1)) begin
            r_col <= '0;
            r_row <= r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   // Latency-matching pipe; x/y/colour only move on valid cycles.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_pv     <= '0;
         r_out_v  <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_colour <= '0;
         for (int i = 0; i < PD; i++) begin
            r_pc[i] <= '0;
            r_pr[i] <= '0;
         end
      end else begin
         r_pv[0] <= (r_state == S_RUN);
         r_pc[0] <= r_col;
         r_pr[0] <= r_row;
         for (int i = 1; i < PD; i++) begin
            r_pv[i] <= r_pv[i-1];
            r_pc[i] <= r_pc[i-1];
            r_pr[i] <= r_pr[i-1];
         end
         r_out_v <= r_pv[PD-1];
         if (r_pv[PD-1]) begin
            r_x <= r_x0 + X_W'(r_pc[PD-1]);
            r_y <= r_y0 + Y_W'(r_pr[PD-1]);
         end
         if (r_out_v) r_colour <= bus.rom_q;
      end
   end

   assign bus.busy        = (r_state != S_IDLE);
   assign bus.done        = (r_state == S_DONE);
   assign bus.rom_address = r_addr;
   assign bus.x           = r_x;
   assign bus.y           = r_y;
   // rom_q is the ROM's registered output, valid in the same cycle as the
   // output stage; r_colour keeps the last value between draws and clears on reset.
   assign bus.plot        = r_out_v && (bus.rom_q != TRANSP);
   assign bus.colour      = r_out_v ? bus.rom_q : r_colour;
endmodule
